// File: rtl/des_round_iter.sv
// Iterative DES core: one Feistel round per clock, 16 rounds per block, fixed 17-cycle latency.
// Optional macro DES_KEYLATCH_EN captures the 768-bit subkey bundle at start instead of reading it live.
module des_round_iter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         decrypt,
    input  logic [0:63]  data_in,
    input  logic [0:767] subkeys,
    output logic         busy,
    output logic         done,
    output logic [0:63]  data_out
);

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

    // Table entries are 1-based DES bit positions; bit 1 is vector index 0.
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    // Each S-box is 64 nibbles, row-major (row = outer bits, col = inner four), entry 0 leftmost.
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    function automatic logic [0:63] des_ip(input logic [0:63] x);
        logic [0:63] y;
        for (int i = 0; i < 64; i++) y[i] = x[IP_T[i] - 1];
        return y;
    endfunction

    function automatic logic [0:63] des_fp(input logic [0:63] x);
        logic [0:63] y;
        for (int i = 0; i < 64; i++) y[i] = x[FP_T[i] - 1];
        return y;
    endfunction

    function automatic logic [0:31] des_f(input logic [0:31] r, input logic [0:47] k);
        logic [0:47] x;
        logic [0:31] s;
        logic [0:31] y;
        logic [5:0]  b;
        logic [5:0]  idx;
        for (int i = 0; i < 48; i++) x[i] = r[E_T[i] - 1];
        x = x ^ k;
        for (int i = 0; i < 8; i++) begin
            b   = x[6*i +: 6];
            idx = {b[5], b[0], b[4:1]};
            s[4*i +: 4] = SBOX[i][(63 - int'(idx)) * 4 +: 4];
        end
        for (int i = 0; i < 32; i++) y[i] = s[P_T[i] - 1];
        return y;
    endfunction

    state_t       r_state;
    state_t       w_state_next;
    logic [3:0]   r_rc;
    logic [0:31]  r_l;
    logic [0:31]  r_r;
    logic         r_decrypt;
    logic [0:63]  r_data_out;
    logic [0:767] w_keys;
    logic [3:0]   w_k_idx;
    logic [0:47]  w_key;
    logic [0:31]  w_l_next;
    logic [0:31]  w_r_next;

`ifdef DES_KEYLATCH_EN
    logic [0:767] r_keys;

    // NOTE: wide key storage carries no reset; it is always rewritten before any round reads it.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && start) r_keys <= subkeys;
    end
    assign w_keys = r_keys;
`else
    assign w_keys = subkeys;
`endif

    // Decrypt walks the key schedule backwards: k16 first.
    assign w_k_idx  = r_decrypt ? (4'd15 - r_rc) : r_rc;
    assign w_key    = w_keys[48*w_k_idx +: 48];
    assign w_l_next = r_r;
    assign w_r_next = r_l ^ des_f(r_r, w_key);

    always_comb begin
        // NOTE: assign the default first so every path drives the signal and no latch is inferred.
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_ROUND;
            S_ROUND: if (r_rc == 4'd15) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rc       <= 4'd0;
            r_l        <= '0;
            r_r        <= '0;
            r_decrypt  <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        {r_l, r_r} <= des_ip(data_in);
                        r_rc       <= 4'd0;
                        r_decrypt  <= decrypt;
                    end
                end
                S_ROUND: begin
                    r_l <= w_l_next;
                    r_r <= w_r_next;
                    // rc parks at 15 rather than wrapping; the last round also loads the result.
                    if (r_rc == 4'd15) r_data_out <= des_fp({w_r_next, w_l_next});
                    else               r_rc       <= r_rc + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign data_out = r_data_out;

endmodule

// File: doc/des_round_iter.md
DES_ROUND_ITER -- requirements
Module: des_round_iter

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: the reset; asynchronous and active-low.
REQ-003 The block SHALL have port start, input, 1 bit: request to process data_in; sampled only in IDLE.
REQ-004 The block SHALL have port decrypt, input, 1 bit: mode select, 0 = encrypt and 1 = decrypt; sampled with start.
REQ-005 The block SHALL have port data_in, input, [0:63]: the plaintext or ciphertext block, with bit 0 as the DES MSB.
REQ-006 The block SHALL have port subkeys, input, [0:767]: the packed round keys; round key k(n) SHALL occupy bits [48(n-1) : 48n-1], so k1 is at [0:47] and k16 at [720:767].
REQ-007 The block SHALL have port busy, output, 1 bit: high in ROUND and DONE.
REQ-008 The block SHALL have port done, output, 1 bit: a one-cycle pulse indicating data_out is valid.
REQ-009 The block SHALL have port data_out, output, [0:63]: the result block; it SHALL hold its value until the next done pulse or reset.

Function
REQ-010 The block SHALL implement a state machine with states IDLE, ROUND and DONE.
REQ-011 In IDLE with start=1 (cycle T), the block SHALL:
- load L and R from the DES initial permutation IP of data_in;
- clear the 4-bit round counter rc;
- latch decrypt;
- go to ROUND.
REQ-012 In IDLE with start=0, the block SHALL hold all registers.
REQ-013 In ROUND, each cycle SHALL perform one Feistel round, L' = R and R' = L xor f(R, K), and then increment rc.
REQ-014 The f function SHALL be the standard DES f: expansion E (32 to 48 bits), xor with K, S-boxes S1..S8 (6 bits in, 4 bits out each), then permutation P.
REQ-015 In encrypt mode, K SHALL be k(rc+1); in decrypt mode, K SHALL be k(16-rc).
REQ-016 When rc=15 and the round completes, the block SHALL go to DONE; exactly 16 rounds SHALL execute, in cycles T+1 to T+16.
REQ-017 In DONE (cycle T+17), data_out SHALL equal FP(R16 || L16), where the halves are swapped before the final permutation FP; done SHALL be 1 and the state SHALL return to IDLE.
REQ-018 Latency SHALL be fixed: done rises 17 cycles after the start sample; the earliest next accepted start is cycle T+18.
REQ-019 start asserted in ROUND or DONE SHALL be ignored; it SHALL NOT be queued.
REQ-020 Changes on data_in or decrypt after cycle T SHALL have no effect on the current operation.
REQ-021 rc SHALL NOT wrap within an operation; the state machine SHALL leave ROUND at rc=15.

Reset
REQ-022 When rst_n=0, the block SHALL immediately force:
- state to IDLE;
- rc, L, R, the mode latch and data_out to 0;
- busy and done to 0.
REQ-023 Reset asserted mid-operation SHALL abort the operation: no done pulse, and data_out SHALL be 0 after reset.
REQ-024 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted as cycle T.

Configuration
REQ-025 Macro DES_KEYLATCH_EN SHALL control whether the round keys are captured internally.
REQ-026 With DES_KEYLATCH_EN defined, all 768 subkey bits SHALL be captured into an internal register at cycle T, and later changes on subkeys SHALL be ignored.
REQ-027 Without DES_KEYLATCH_EN, subkeys SHALL be read live every ROUND cycle, and the source SHALL hold them stable from T to T+16; there SHALL be no 768-bit register.

Verification
REQ-028 Encrypt vector: keys from key 133457799BBCDFF1, data_in 0123456789ABCDEF, decrypt=0 -> at T+17, done=1 and data_out=85E813540F0AB405.
REQ-029 Decrypt vector: same key, data_in 85E813540F0AB405, decrypt=1 -> data_out=0123456789ABCDEF.
REQ-030 Second encrypt vector: key 0E329232EA6D0D73, data_in 8787878787878787 -> data_out=0000000000000000.
REQ-031 Start while busy: pulse start at T+5 with a different data_in -> result is unchanged, exactly one done pulse, busy stays 1 through T+17.
REQ-032 Reset mid-operation: rst_n=0 at T+8 -> busy=0, done=0, data_out=0; a new start then completes normally after 17 cycles.
REQ-033 With DES_KEYLATCH_EN defined, corrupt subkeys at T+3 -> data_out=85E813540F0AB405; without the macro, the result SHALL differ.
